// File: rtl/mac_port_arbiter.sv
// mac_port_arbiter: shares one cmac request/reply port between N_REQ
// execution-unit requesters. Round-robin tx arbitration with the grant held
// until the cmac accepts or the requester withdraws; an owner FIFO records
// the issuing requester of every read so in-order replies are routed back.
//
// line_acc_req packing (MSB to LSB): {addr, rqt, wmsk, dat}; rqt=1 is a write.
module mac_port_arbiter #(
    parameter int N_REQ     = 3,
    parameter int OWN_DEPTH = 4,
    parameter int ADDR_W    = 32,
    parameter int DAT_W     = 32,
    parameter int WMSK_W    = DAT_W / 8,
    parameter int REQ_W     = ADDR_W + 1 + WMSK_W + DAT_W,
    parameter int CNT_W     = $clog2(OWN_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_tx_rp,
    input  logic [N_REQ*REQ_W-1:0] req_tx_req,
    output logic [N_REQ-1:0]       req_tx_ra,
    output logic [N_REQ-1:0]       req_rx_rp,
    output logic [REQ_W-1:0]       req_rx_req,
    input  logic [N_REQ-1:0]       req_rx_ra,
    output logic                   mac_tx_rp,
    output logic [REQ_W-1:0]       mac_tx_req,
    input  logic                   mac_tx_ra,
    input  logic                   mac_rx_rp,
    input  logic [REQ_W-1:0]       mac_rx_req,
    output logic                   mac_rx_ra,
    output logic [CNT_W-1:0]       own_cnt,
    output logic                   err
);

    localparam int GW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int AW      = (OWN_DEPTH > 1) ? $clog2(OWN_DEPTH) : 1;
    localparam int RQT_BIT = DAT_W + WMSK_W;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_reg, state_next;
    logic [GW-1:0]    gnt_reg, gnt_next;
    logic [GW-1:0]    last_reg, last_next;

    logic [GW-1:0]    own_mem [OWN_DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] own_cnt_reg;
    logic             err_reg;

    logic [REQ_W-1:0] tx_req_arr [N_REQ];
    logic [N_REQ-1:0] elig;
    logic             own_full, own_empty;
    logic             pick_valid;
    logic [GW-1:0]    pick_idx;
    logic             push, pop, orphan;
    logic [GW-1:0]    head;

    assign own_full  = (own_cnt_reg >= CNT_W'(OWN_DEPTH));
    assign own_empty = (own_cnt_reg == '0);
    assign head      = own_mem[rd_ptr_reg];

    // Unpack per-requester requests; a read is only eligible while the owner
    // FIFO has room, so a push can never hit a full FIFO.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign tx_req_arr[gi] = req_tx_req[gi*REQ_W +: REQ_W];
            assign elig[gi]       = req_tx_rp[gi] & (tx_req_arr[gi][RQT_BIT] | ~own_full);
        end
    endgenerate

    // Index reached by stepping k places past base, wrapping at N_REQ.
    function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return GW'(s);
    endfunction

    // Round-robin pick: first eligible index starting at last+1. Scanning
    // from the far end lets the nearest eligible index overwrite the others.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (elig[rr_idx(last_reg, k)]) begin
                pick_valid = 1'b1;
                pick_idx   = rr_idx(last_reg, k);
            end
        end
    end

    // Tx FSM next-state and tx-side outputs (muxed from the registered grant).
    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        last_next  = last_reg;
        push       = 1'b0;
        mac_tx_rp  = 1'b0;
        req_tx_ra  = '0;
        mac_tx_req = tx_req_arr[gnt_reg];
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    gnt_next   = pick_idx;
                    last_next  = pick_idx;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                mac_tx_rp          = req_tx_rp[gnt_reg];
                req_tx_ra[gnt_reg] = mac_tx_ra;
                if (!req_tx_rp[gnt_reg]) begin
                    // requester withdrew: drop the grant without a transfer
                    state_next = IDLE;
                end else if (mac_tx_ra) begin
                    state_next = IDLE;
                    push       = ~tx_req_arr[gnt_reg][RQT_BIT];
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Rx routing: replies go to the FIFO head owner; with no owner the reply
    // is drained and flagged as an orphan.
    always_comb begin
        req_rx_rp = '0;
        mac_rx_ra = 1'b0;
        pop       = 1'b0;
        orphan    = 1'b0;
        if (!own_empty) begin
            req_rx_rp[head] = mac_rx_rp;
            mac_rx_ra       = req_rx_ra[head];
            pop             = mac_rx_rp & req_rx_ra[head];
        end else begin
            mac_rx_ra = mac_rx_rp;
            orphan    = mac_rx_rp;
        end
    end

    assign req_rx_req = mac_rx_req;
    assign own_cnt    = own_cnt_reg;
    assign err        = err_reg;

    // Control state: FSM, grant pointers, FIFO pointers/count, sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            gnt_reg     <= '0;
            last_reg    <= GW'(N_REQ - 1);
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            own_cnt_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            last_reg  <= last_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   own_cnt_reg <= own_cnt_reg + 1'b1;
                2'b01:   own_cnt_reg <= own_cnt_reg - 1'b1;
                default: own_cnt_reg <= own_cnt_reg;
            endcase
            if (orphan) err_reg <= 1'b1;
        end
    end

    // Owner storage; contents are don't-care outside the valid pointer window.
    always_ff @(posedge clk) begin
        if (push) own_mem[wr_ptr_reg] <= gnt_reg;
    end

endmodule
